time_of_day: RTL and testbench

Time-of-day and alarm core, fed by the one-second tick counter's single-cycle `tick` pulse. It keeps 24-hour hours/minutes/seconds, holds an alarm setting, and runs the alarm ring/snooze state machine. Its binary outputs drive the display formatter and the buzzer driver.

---
 rtl/time_of_day.sv | 161 ++++++++++++++++
 tb/tb_time_of_day.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day.sv
// Time-of-day clock with alarm: 24h h:m:s, alarm setting and
// ring/snooze state machine driven by a 1 Hz tick.
module time_of_day #(
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] al_hr,
  output logic [5:0] al_min,
  output logic       buzz
);

  localparam int MAXT = (RING_TICKS > SNOOZE_TICKS) ?
                        RING_TICKS : SNOOZE_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  localparam logic [CW-1:0] RING_C = CW'(RING_TICKS);
  localparam logic [CW-1:0] SNZ_C  = CW'(SNOOZE_TICKS);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNZ
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  hr_q, hr_d, al_hr_q, al_hr_d;
  logic [5:0]  min_q, min_d, sec_q, sec_d;
  logic [5:0]  al_min_q, al_min_d;
  logic [CW-1:0] ring_q, ring_d, snz_q, snz_d;
  logic [CW-1:0] ring_inc;
  logic        tick_q;
  logic        set_time, set_alarm, match, abort;

  assign set_time  = (mode == 2'b01);
  assign set_alarm = (mode == 2'b10);
  assign abort     = set_time | stop | ~alarm_en;
  assign ring_inc  = ring_q + ONE_C;

  // tick_q trails the tick that just rolled sec to 0
  assign match = tick_q && (hr_q == al_hr_q) &&
                 (min_q == al_min_q) && (sec_q == 6'd0) &&
                 alarm_en && !set_time;

  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (set_time) begin
      sec_d = '0;
      if (inc_min)
        min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
      if (inc_hr)
        hr_d = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (set_alarm) begin
      if (inc_min)
        al_min_d = (al_min_q == 6'd59) ? '0 : al_min_q + 6'd1;
      if (inc_hr)
        al_hr_d = (al_hr_q == 5'd23) ? '0 : al_hr_q + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    unique case (state_q)
      IDLE: begin
        if (match) begin
          state_d = RING;
          ring_d  = '0;
        end
      end
      RING: begin
        if (abort) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNZ;
          snz_d   = SNZ_C;
        end else if (tick) begin
          ring_d = ring_inc;
          if (ring_inc == RING_C)
            state_d = IDLE;
        end
      end
      SNZ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          snz_d = snz_q - ONE_C;
          if (snz_q == ONE_C) begin
            state_d = RING;
            ring_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hr_q     <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      al_hr_q  <= '0;
      al_min_q <= '0;
      ring_q   <= '0;
      snz_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      ring_q   <= ring_d;
      snz_q    <= snz_d;
      tick_q   <= tick;
    end
  end

  assign hr     = hr_q;
  assign min    = min_q;
  assign sec    = sec_q;
  assign al_hr  = al_hr_q;
  assign al_min = al_min_q;
  assign buzz   = (state_q == RING);

endmodule

// File: tb/tb_time_of_day.sv
// Bench for time_of_day: directed scenarios plus random traffic
// checked against a seconds-of-day reference model.
module tb_time_of_day;

  localparam int RT = 5;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic       alarm_en = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] hr, al_hr;
  logic [5:0] min, sec, al_min;
  logic       buzz;

  int n_tests = 0;
  int n_fail  = 0;

  // model: seconds of day, alarm minute of day, ring state
  int m_tod, m_al, m_st, m_rc, m_sc;
  bit m_td;

  time_of_day #(
    .RING_TICKS  (RT),
    .SNOOZE_TICKS(ST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .mode    (mode),
    .inc_min (inc_min),
    .inc_hr  (inc_hr),
    .alarm_en(alarm_en),
    .snooze  (snooze),
    .stop    (stop),
    .hr      (hr),
    .min     (min),
    .sec     (sec),
    .al_hr   (al_hr),
    .al_min  (al_min),
    .buzz    (buzz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_al = 0; m_st = 0;
    m_rc = 0; m_sc = 0; m_td = 0;
  endtask

  task automatic model_step(input bit t, input bit [1:0] md,
                            input bit im, input bit ih,
                            input bit sn, input bit sp,
                            input bit en);
    bit set_t, hit;
    int h, m;
    set_t = (md == 2'b01);
    hit = m_td && (m_tod / 60 == m_al) && (m_tod % 60 == 0) &&
          en && !set_t;
    if (m_st == 0) begin
      if (hit) begin m_st = 1; m_rc = 0; end
    end else if (set_t || sp || !en) begin
      m_st = 0;
    end else if (m_st == 1) begin
      if (sn) begin
        m_st = 2; m_sc = ST;
      end else if (t) begin
        m_rc++;
        if (m_rc == RT) m_st = 0;
      end
    end else if (t) begin
      m_sc--;
      if (m_sc == 0) begin m_st = 1; m_rc = 0; end
    end
    h = m_tod / 3600;
    m = (m_tod / 60) % 60;
    if (set_t) begin
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      m_tod = h * 3600 + m * 60;
    end else if (t) begin
      m_tod = (m_tod + 1) % 86400;
    end
    if (md == 2'b10) begin
      h = m_al / 60;
      m = m_al % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      m_al = h * 60 + m;
    end
    m_td = t;
  endtask

  task automatic check_all();
    chk("hr", hr, m_tod / 3600);
    chk("min", min, (m_tod / 60) % 60);
    chk("sec", sec, m_tod % 60);
    chk("al_hr", al_hr, m_al / 60);
    chk("al_min", al_min, m_al % 60);
    chk("buzz", buzz, (m_st == 1) ? 1 : 0);
  endtask

  task automatic step(input bit t, input bit [1:0] md,
                      input bit im, input bit ih,
                      input bit sn, input bit sp);
    @(negedge clk);
    tick = t; mode = md; inc_min = im;
    inc_hr = ih; snooze = sn; stop = sp;
    @(posedge clk);
    model_step(t, md, im, ih, sn, sp, alarm_en);
    #1 check_all();
  endtask

  // place time one minute before the alarm and tick into it
  task automatic goto_fire();
    int tgt;
    alarm_en = 1'b1;
    tgt = (m_al + 1439) % 1440;
    step(0, 2'b01, 0, 0, 0, 0);
    while (m_tod / 3600 != tgt / 60) step(0, 2'b01, 0, 1, 0, 0);
    while ((m_tod / 60) % 60 != tgt % 60)
      step(0, 2'b01, 1, 0, 0, 0);
    repeat (59) step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    chk("fire_pre", buzz, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    chk("fire_buzz", buzz, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    chk("rst_time", {hr, min, sec}, 0);
    chk("rst_alarm", {al_hr, al_min}, 0);
    chk("rst_buzz", buzz, 0);
    @(negedge clk);
    rst = 1'b1;

    // rollover
    repeat (23) step(0, 2'b01, 0, 1, 0, 0);
    repeat (59) step(0, 2'b01, 1, 0, 0, 0);
    repeat (58) step(1, 2'b00, 0, 0, 0, 0);
    chk("pre_roll", {hr, min, sec}, {5'd23, 6'd59, 6'd58});
    step(1, 2'b00, 0, 0, 0, 0);
    chk("roll_59", {hr, min, sec}, {5'd23, 6'd59, 6'd59});
    step(1, 2'b00, 0, 0, 0, 0);
    chk("roll_0", {hr, min, sec}, 0);

    // set time
    repeat (10) step(0, 2'b01, 0, 1, 0, 0);
    repeat (20) step(0, 2'b01, 1, 0, 0, 0);
    repeat (35) step(1, 2'b00, 0, 0, 0, 0);
    chk("t_102035", {hr, min, sec}, {5'd10, 6'd20, 6'd35});
    step(0, 2'b01, 0, 0, 0, 0);
    chk("set_sec0", sec, 0);
    repeat (3) step(1, 2'b01, 0, 0, 0, 0);
    chk("frozen", {hr, min, sec}, {5'd10, 6'd20, 6'd0});
    repeat (39) step(0, 2'b01, 1, 0, 0, 0);
    step(0, 2'b01, 1, 0, 0, 0);
    chk("min_wrap", {hr, min}, {5'd10, 6'd0});
    repeat (13) step(0, 2'b01, 0, 1, 0, 0);
    repeat (59) step(0, 2'b01, 1, 0, 0, 0);
    step(0, 2'b01, 1, 1, 0, 0);
    chk("both_wrap", {hr, min}, 0);

    // alarm fire at 00:01
    step(0, 2'b10, 1, 0, 0, 0);
    chk("al_set", {al_hr, al_min}, {5'd0, 6'd1});
    repeat (59) step(1, 2'b00, 0, 0, 0, 0);
    alarm_en = 1'b1;
    step(1, 2'b00, 0, 0, 0, 0);
    chk("fire_n1", buzz, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    chk("fire_n2", buzz, 1);
    repeat (4) step(1, 2'b00, 0, 0, 0, 0);
    chk("ring_4", buzz, 1);
    step(1, 2'b00, 0, 0, 0, 0);
    chk("ring_5", buzz, 0);

    // snooze and re-ring, then stop+snooze
    goto_fire();
    step(0, 2'b00, 0, 0, 1, 0);
    chk("snz_low", buzz, 0);
    repeat (2) step(1, 2'b00, 0, 0, 0, 0);
    chk("snz_2", buzz, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    chk("snz_rering", buzz, 1);
    step(0, 2'b00, 0, 0, 1, 1);
    chk("stop_snz", buzz, 0);
    repeat (4) step(1, 2'b00, 0, 0, 0, 0);
    chk("no_rering", buzz, 0);

    // disarm in snooze, mode 01 in ring
    goto_fire();
    step(0, 2'b00, 0, 0, 1, 0);
    alarm_en = 1'b0;
    step(0, 2'b00, 0, 0, 0, 0);
    repeat (4) step(1, 2'b00, 0, 0, 0, 0);
    chk("disarm_quiet", buzz, 0);
    goto_fire();
    step(0, 2'b01, 0, 0, 0, 0);
    chk("mode1_ring", buzz, 0);

    // async reset mid-ring
    goto_fire();
    #3 rst = 1'b0;
    #1;
    chk("arst_buzz", buzz, 0);
    chk("arst_out", {hr, min, sec, al_hr, al_min}, 0);
    model_reset();
    @(negedge clk);
    tick = 0; mode = 0; inc_min = 0;
    inc_hr = 0; snooze = 0; stop = 0;
    rst = 1'b1;
    step(1, 2'b00, 0, 0, 0, 0);
    chk("arst_sec1", sec, 1);

    // random traffic
    repeat (1500) begin
      if ($urandom_range(0, 99) == 0) begin
        goto_fire();
      end else begin
        int r;
        bit [1:0] md;
        r = $urandom_range(0, 9);
        md = (r < 6) ? 2'b00 : (r == 6) ? 2'b11 :
             (r == 7) ? 2'b10 : 2'b01;
        if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
        step($urandom_range(0, 1) == 1, md,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 24) == 0,
             $urandom_range(0, 39) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
